// File: rtl/mux_pipe_if.sv
// mux_pipe_if: bundle of the channel-side and output-side handshake signals
// of mux_pipe. The master modport belongs to whoever drives the channels and
// consumes y; the slave modport belongs to mux_pipe itself.
interface mux_pipe_if #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] ch_data;
    logic [CHANNELS-1:0]       ch_valid;
    logic [CHANNELS-1:0]       ch_ready;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic [WIDTH-1:0]          y;
    logic                      y_valid;
    logic [SEL_W-1:0]          y_ch;
    logic                      out_ready;

    modport master (
        output ch_data, ch_valid, sel, mode, out_ready,
        input  ch_ready, y, y_valid, y_ch
    );

    modport slave (
        input  ch_data, ch_valid, sel, mode, out_ready,
        output ch_ready, y, y_valid, y_ch
    );
endinterface

// File: rtl/mux_pipe.sv
// mux_pipe: registered N-to-1 channel multiplexer with a one-word output slot.
// mode=0 takes the channel named by sel; mode=1 scans round-robin from the
// channel after the last one granted. A word moves into y when the slot is
// free (empty or being consumed) and the candidate channel is valid; the
// candidate then sees a one-cycle ch_ready strobe.
//
// Handshake: a channel word is accepted in a cycle where ch_valid[i] and
// ch_ready[i] are both 1 at the rising edge; y is consumed in a cycle where
// y_valid and out_ready are both 1 at the rising edge.
//
// Optional feature: define MUX_PIPE_STALL_CNT_EN to add a 16-bit saturating
// stall_cnt output counting cycles with y_valid=1 and out_ready=0.
module mux_pipe #(
    parameter int WIDTH    = 2,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    mux_pipe_if.slave  bus
`ifdef MUX_PIPE_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    logic [WIDTH-1:0] r_y;
    logic             r_y_valid;
    logic [SEL_W-1:0] r_y_ch;
    logic [SEL_W-1:0] r_last_grant;

    logic             w_slot_free;
    logic [SEL_W-1:0] w_cand;
    logic             w_cand_ok;
    logic             w_cand_valid;
    logic [WIDTH-1:0] w_cand_data;
    logic             w_xfer;

    assign w_slot_free = !r_y_valid || bus.out_ready;

    // Candidate selection: fixed select (out-of-range sel gives none) or
    // round-robin scan starting just after the last granted channel.
    always_comb begin
        int v_idx;
        w_cand    = '0;
        w_cand_ok = 1'b0;
        v_idx     = 0;
        if (!bus.mode) begin
            w_cand    = bus.sel;
            w_cand_ok = (int'(bus.sel) < CHANNELS);
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                v_idx = int'(r_last_grant) + k;
                if (v_idx >= CHANNELS) begin
                    v_idx = v_idx - CHANNELS;
                end
                if (!w_cand_ok && bus.ch_valid[v_idx]) begin
                    w_cand    = SEL_W'(v_idx);
                    w_cand_ok = 1'b1;
                end
            end
        end
    end

    // Pick only the candidate's valid and data; other channels never reach y.
    always_comb begin
        w_cand_valid = 1'b0;
        w_cand_data  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_cand_ok && (int'(w_cand) == i)) begin
                w_cand_valid = bus.ch_valid[i];
                w_cand_data  = bus.ch_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_xfer = rst_n && w_slot_free && w_cand_valid;

    // One-hot accept strobe at the candidate on a transfer, zero otherwise.
    always_comb begin
        bus.ch_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_xfer && (int'(w_cand) == i)) begin
                bus.ch_ready[i] = 1'b1;
            end
        end
    end

    // Output slot: load on transfer, drop valid on a consume without refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y          <= '0;
            r_y_ch       <= '0;
            r_y_valid    <= 1'b0;
            r_last_grant <= SEL_W'(CHANNELS - 1);
        end else if (w_xfer) begin
            r_y          <= w_cand_data;
            r_y_ch       <= w_cand;
            r_y_valid    <= 1'b1;
            r_last_grant <= w_cand;
        end else if (bus.out_ready) begin
            r_y_valid    <= 1'b0;
        end
    end

    assign bus.y       = r_y;
    assign bus.y_ch    = r_y_ch;
    assign bus.y_valid = r_y_valid;

`ifdef MUX_PIPE_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of cycles the held word waits on downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_y_valid && !bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_mux_pipe.sv
// tb_mux_pipe: directed-vector bench for mux_pipe. Instance a uses the default
// 4-channel configuration; instance b uses 5 channels with a 3-bit select to
// exercise the out-of-range select case.
module tb_mux_pipe;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mux_pipe_if #(.WIDTH(2), .CHANNELS(4), .SEL_W(2)) a ();
    mux_pipe_if #(.WIDTH(2), .CHANNELS(5), .SEL_W(3)) b ();

`ifdef MUX_PIPE_STALL_CNT_EN
    logic [15:0] a_stall_cnt;
    logic [15:0] b_stall_cnt;
`endif

    mux_pipe #(.WIDTH(2), .CHANNELS(4), .SEL_W(2)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (a.slave)
`ifdef MUX_PIPE_STALL_CNT_EN
        ,
        .stall_cnt (a_stall_cnt)
`endif
    );

    mux_pipe #(.WIDTH(2), .CHANNELS(5), .SEL_W(3)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (b.slave)
`ifdef MUX_PIPE_STALL_CNT_EN
        ,
        .stall_cnt (b_stall_cnt)
`endif
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 2 ns later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    logic [1:0] a_d [4];

    initial begin
        n_checks = 0;
        n_errors = 0;
        a_d = '{2'b01, 2'b10, 2'b11, 2'b00};

        // Reset with a valid candidate present: nothing may be accepted.
        rst_n       = 1'b0;
        a.ch_data   = {a_d[3], a_d[2], a_d[1], a_d[0]};
        a.ch_valid  = 4'b0100;
        a.sel       = 2'd2;
        a.mode      = 1'b0;
        a.out_ready = 1'b1;
        b.ch_data   = {2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
        b.ch_valid  = 5'b11111;
        b.sel       = 3'd6;
        b.mode      = 1'b0;
        b.out_ready = 1'b1;
        #3;
        check("rst_y_valid", 32'(a.y_valid), 32'd0);
        check("rst_y", 32'(a.y), 32'd0);
        check("rst_y_ch", 32'(a.y_ch), 32'd0);
        check("rst_ch_ready", 32'(a.ch_ready), 32'd0);

        // Fixed select, channel 2
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        check("sel2_ch_ready", 32'(a.ch_ready), 32'b0100);
        tick();
        check("sel2_y", 32'(a.y), 32'd3);
        check("sel2_y_ch", 32'(a.y_ch), 32'd2);
        check("sel2_y_valid", 32'(a.y_valid), 32'd1);
        a.ch_valid = 4'b0000;
        settle();
        check("idle_ch_ready", 32'(a.ch_ready), 32'd0);
        tick();
        check("drain_y_valid", 32'(a.y_valid), 32'd0);
        check("drain_y_hold", 32'(a.y), 32'd3);
        check("drain_y_ch_hold", 32'(a.y_ch), 32'd2);

        // Round robin, all channels valid, from a fresh reset
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        a.mode = 1'b1;
        a.ch_valid = 4'b1111;
        settle();
        check("rr_first_ready", 32'(a.ch_ready), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr_y_ch_%0d", k), 32'(a.y_ch), 32'(k % 4));
            check($sformatf("rr_y_%0d", k), 32'(a.y), 32'(a_d[k % 4]));
            check($sformatf("rr_y_valid_%0d", k), 32'(a.y_valid), 32'd1);
        end

        // Round robin over channels 1 and 3 only (last grant is 0)
        a.ch_valid = 4'b1010;
        settle();
        check("rr2_ready0", 32'(a.ch_ready), 32'b0010);
        tick();
        check("rr2_y_ch0", 32'(a.y_ch), 32'd1);
        check("rr2_ready1", 32'(a.ch_ready), 32'b1000);
        tick();
        check("rr2_y_ch1", 32'(a.y_ch), 32'd3);
        check("rr2_ready2", 32'(a.ch_ready), 32'b0010);
        tick();
        check("rr2_y_ch2", 32'(a.y_ch), 32'd1);
        check("rr2_y2", 32'(a.y), 32'(a_d[1]));

        // Stall for 5 cycles holding channel 1's word
        a.out_ready = 1'b0;
        a.ch_valid = 4'b1111;
        settle();
        check("stall_ready_pre", 32'(a.ch_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("stall_y_%0d", k), 32'(a.y), 32'(a_d[1]));
            check($sformatf("stall_y_ch_%0d", k), 32'(a.y_ch), 32'd1);
            check($sformatf("stall_y_valid_%0d", k), 32'(a.y_valid), 32'd1);
            check($sformatf("stall_ready_%0d", k), 32'(a.ch_ready), 32'd0);
        end
`ifdef MUX_PIPE_STALL_CNT_EN
        check("stall_cnt", 32'(a_stall_cnt), 32'd5);
`endif

        // Mode/sel change while a word is held does not touch it
        a.mode = 1'b0;
        a.sel = 2'd3;
        a.ch_valid = 4'b1000;
        settle();
        check("chg_y_ch_hold", 32'(a.y_ch), 32'd1);
        check("chg_ready", 32'(a.ch_ready), 32'd0);
        a.out_ready = 1'b1;
        settle();
        check("chg_ready_free", 32'(a.ch_ready), 32'b1000);
        tick();
        check("chg_y_ch", 32'(a.y_ch), 32'd3);
        check("chg_y", 32'(a.y), 32'(a_d[3]));
        check("chg_y_valid", 32'(a.y_valid), 32'd1);

        // Round robin after last grant 3, then async reset mid-stream
        a.mode = 1'b1;
        a.ch_valid = 4'b1111;
        tick();
        check("pre_rst_y_ch", 32'(a.y_ch), 32'd0);
        check("pre_rst_y_valid", 32'(a.y_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_y_valid", 32'(a.y_valid), 32'd0);
        check("async_rst_y", 32'(a.y), 32'd0);
        check("async_rst_ready", 32'(a.ch_ready), 32'd0);
`ifdef MUX_PIPE_STALL_CNT_EN
        check("async_rst_stall_cnt", 32'(a_stall_cnt), 32'd0);
`endif
        #2;
        rst_n = 1'b1;
        a.ch_valid = 4'b1010;
        settle();
        check("post_rst_ready", 32'(a.ch_ready), 32'b0010);
        tick();
        check("post_rst_y_ch", 32'(a.y_ch), 32'd1);
        check("post_rst_y", 32'(a.y), 32'(a_d[1]));

        // 5-channel instance: sel=6 is out of range, nothing moves
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("b_oor_y_valid_%0d", k), 32'(b.y_valid), 32'd0);
            check($sformatf("b_oor_ready_%0d", k), 32'(b.ch_ready), 32'd0);
        end
        b.sel = 3'd4;
        settle();
        check("b_sel4_ready", 32'(b.ch_ready), 32'b10000);
        tick();
        check("b_sel4_y_ch", 32'(b.y_ch), 32'd4);
        check("b_sel4_y", 32'(b.y), 32'd2);
        check("b_sel4_y_valid", 32'(b.y_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_pipe.md
MUX_PIPE -- requirements
Module: mux_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, meaning the data bits per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning the number of input channels (range 2..16).
REQ-003 The block SHALL have parameter SEL_W, default 2, meaning the select width, equal to ceil(log2(CHANNELS)).
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port ch_data, input, CHANNELS*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port ch_valid, input, CHANNELS bits: per-channel data-valid.
REQ-008 Port ch_ready, output, CHANNELS bits: per-channel accept strobe.
REQ-009 Port sel, input, SEL_W bits: channel select when mode=0.
REQ-010 Port mode, input, 1 bit: 0 = fixed select; 1 = round-robin scan.
REQ-011 Port y, output, WIDTH bits: registered output data.
REQ-012 Port y_valid, output, 1 bit: y holds an unconsumed word.
REQ-013 Port y_ch, output, SEL_W bits: index of the channel that sourced y.
REQ-014 Port out_ready, input, 1 bit: downstream accepts y this cycle.

Function
REQ-015 The output register SHALL be able to load ("slot free") when y_valid=0 or out_ready=1.
REQ-016 The channel candidate in mode=0 SHALL be sel; sel>=CHANNELS SHALL yield no candidate.
REQ-017 The channel candidate in mode=1 SHALL be the first i with ch_valid[i]=1, searching upward from (last_grant+1) mod CHANNELS with wrap-around.
REQ-018 A transfer SHALL occur when slot free and ch_valid[candidate]=1; ch_ready SHALL then be one-hot at the candidate, otherwise all zero (combinational).
REQ-019 On a transfer, y, y_ch and y_valid=1 SHALL update at the next edge; latency input-to-output is 1 cycle.
REQ-020 When out_ready=1 and no transfer occurs, y_valid SHALL clear at the next edge; y and y_ch SHALL hold.
REQ-021 Simultaneous consume and transfer SHALL sustain one word per cycle with no bubble.
REQ-022 When y_valid=1 and out_ready=0, y, y_ch and y_valid SHALL hold stable and ch_ready SHALL be all zero.
REQ-023 last_grant SHALL update to the candidate only on a transfer, in either mode.
REQ-024 A mode or sel change SHALL take effect on the next candidate evaluation and SHALL NOT alter a word already in y.
REQ-025 ch_data of non-selected channels SHALL never influence y.

Reset
REQ-026 On rst_n=0, regardless of clk, y, y_ch and y_valid SHALL be 0 and last_grant SHALL be CHANNELS-1, so the first scan starts at channel 0.
REQ-027 Reset asserted mid-operation SHALL discard any held word.
REQ-028 ch_ready SHALL be all zero while rst_n=0.

Configuration
REQ-029 The macro MUX_PIPE_STALL_CNT_EN SHALL control a stall counter.
REQ-030 With MUX_PIPE_STALL_CNT_EN defined, the block SHALL add output stall_cnt, 16 bits.
REQ-031 stall_cnt SHALL increment each cycle y_valid=1 and out_ready=0, saturate at 0xFFFF and reset to 0.
REQ-032 Without MUX_PIPE_STALL_CNT_EN, the port and its logic SHALL be absent and behaviour is otherwise identical.

Verification
REQ-033 Reset release, mode=0, sel=2, ch_valid=4'b0100, ch_data[5:4]=2'b11, out_ready=1 -> next cycle y=2'b11, y_ch=2, y_valid=1; ch_ready=4'b0100 in the accept cycle.
REQ-034 mode=1, ch_valid=4'b1111 held, out_ready=1 -> y_ch sequence 0,1,2,3,0 on consecutive cycles.
REQ-035 mode=1, ch_valid=4'b1010 -> y_ch alternates 1,3,1; channels 0 and 2 are never granted.
REQ-036 y_valid=1, out_ready=0 for 5 cycles -> y stable, ch_ready=0; with MUX_PIPE_STALL_CNT_EN, stall_cnt=5.
REQ-037 rst_n pulsed low mid-stream, asynchronously between edges -> y_valid=0 immediately; the first grant after release is the lowest valid channel.
REQ-038 CHANNELS=5, SEL_W=3, sel=6, ch_valid all 1 -> no transfer, y_valid stays 0.
